// File: rtl/dequant.sv
// dequant: int8 -> accumulator-domain, out = rne(((q - Z) * M) >>> E).
// Define DEQUANT_SAT_EN to clamp the result instead of two's-complement wrap.
module dequant #(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 32,
  localparam int SHAMT_SZ = $clog2(2*D_W_ACC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [D_W-1:0]      quant_data_in,
  input  logic                       quant_valid_in,
  input  logic                       quant_last_in,
  input  logic [3:0]                 quant_keep_in,
  output logic                       back_ready_out,
  input  logic                       cfg_valid_in,
  output logic                       cfg_ready_out,
  input  logic signed [D_W-1:0]      Z_data_in,
  input  logic signed [D_W_ACC-1:0]  M_data_in,
  input  logic [SHAMT_SZ-1:0]        E_data_in,
  input  logic                       back_ready_in,
  output logic signed [D_W_ACC-1:0]  A_data,
  output logic                       A_valid,
  output logic                       A_last,
  output logic [3:0]                 A_keep
);

  localparam int PW = D_W_ACC + D_W + 1;
  localparam int XW = 2 * D_W_ACC;
  localparam logic [XW-1:0] ONE = XW'(1);

  logic [D_W-1:0]      z_q;
  logic [D_W_ACC-1:0]  m_q;
  logic [SHAMT_SZ-1:0] e_q;

  logic           v1, l1;
  logic [3:0]     k1;
  logic [D_W:0]   d1;
  logic           v2, l2;
  logic [3:0]     k2;
  logic [PW-1:0]  p2;

  logic adv, accept, cfg_load;

  assign adv            = !A_valid || back_ready_in;
  assign back_ready_out = adv && !cfg_valid_in;
  assign accept         = quant_valid_in && back_ready_out;
  assign cfg_ready_out  = !v1 && !v2 && !A_valid;
  assign cfg_load       = cfg_valid_in && cfg_ready_out;

  logic signed [XW-1:0] ext;
  logic [XW-1:0]        mask, frac, half;
  logic                 lsb, inc;
  logic [D_W_ACC-1:0]   res;

`ifdef DEQUANT_SAT_EN
  localparam logic signed [XW-1:0] MAXV =
    {{(XW-D_W_ACC+1){1'b0}}, {(D_W_ACC-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV =
    {{(XW-D_W_ACC+1){1'b1}}, {(D_W_ACC-1){1'b0}}};
  logic signed [XW-1:0] shr, rnd;
`else
  logic [D_W_ACC-1:0] shr_w;
`endif

  // Stage 3: arithmetic shift, then round-half-even on the dropped bits
  always_comb begin
    ext  = $signed({{(XW-PW){p2[PW-1]}}, p2});
    mask = (ONE << e_q) - ONE;
    frac = ext & mask;
    half = ONE << (e_q - 1'b1);
`ifdef DEQUANT_SAT_EN
    shr = ext >>> e_q;
    lsb = shr[0];
`else
    shr_w = D_W_ACC'(ext >>> e_q);
    lsb   = shr_w[0];
`endif
    inc = (e_q != '0) &&
          ((frac > half) || ((frac == half) && lsb));
`ifdef DEQUANT_SAT_EN
    rnd = shr + $signed({{(XW-1){1'b0}}, inc});
    if (rnd > MAXV)
      res = MAXV[D_W_ACC-1:0];
    else if (rnd < MINV)
      res = MINV[D_W_ACC-1:0];
    else
      res = rnd[D_W_ACC-1:0];
`else
    res = shr_w + {{(D_W_ACC-1){1'b0}}, inc};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q     <= '0;
      m_q     <= D_W_ACC'(1);
      e_q     <= '0;
      v1      <= 1'b0;
      l1      <= 1'b0;
      k1      <= '0;
      d1      <= '0;
      v2      <= 1'b0;
      l2      <= 1'b0;
      k2      <= '0;
      p2      <= '0;
      A_data  <= '0;
      A_valid <= 1'b0;
      A_last  <= 1'b0;
      A_keep  <= '0;
    end else begin
      if (cfg_load) begin
        z_q <= Z_data_in;
        m_q <= M_data_in;
        e_q <= E_data_in;
      end
      if (adv) begin
        v1 <= accept;
        if (accept) begin
          d1 <= {quant_data_in[D_W-1], quant_data_in}
              - {z_q[D_W-1], z_q};
          l1 <= quant_last_in;
          k1 <= quant_keep_in;
        end
        v2 <= v1;
        if (v1) begin
          p2 <= $signed({{(PW-D_W-1){d1[D_W]}}, d1})
              * $signed({{(PW-D_W_ACC){m_q[D_W_ACC-1]}}, m_q});
          l2 <= l1;
          k2 <= k1;
        end
        A_valid <= v2;
        if (v2) begin
          A_data <= res;
          A_last <= l2;
          A_keep <= k2;
        end
      end
    end
  end

endmodule
